morph_filter3x3: RTL and testbench

- Streaming 3x3 binary morphology filter for the NTSC luminance path; a parametrised successor to the fixed dilation block.
- Input luma is binarised against a runtime threshold. A selectable operator then computes one of: binarise, dilate, erode, morphological gradient.
- The operator is applied over a line-buffered 3x3 window. A per-frame foreground pixel count is published for the object tracker.
- Sits between the NTSC decoder pixel stream and the display/centroid logic.

---
 rtl/morph_filter3x3.sv | 178 +++++++++++++++++
 tb/tb_morph_filter3x3.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/morph_filter3x3.sv
// Streaming 3x3 binary morphology (binarise/dilate/erode/gradient) with per-frame foreground count.
// Latency: one registered cycle from an accepted in_valid to out_valid; output offset by (-1,-1).
// Backpressure: none; every in_valid pixel is consumed and produces exactly one output.
module morph_filter3x3 #(
    parameter int WIDTH    = 8,
    parameter int MAX_COLS = 1024,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_sol,
    input  logic [WIDTH-1:0] in_pixel,
    input  logic [WIDTH-1:0] threshold,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pixel,
    output logic             out_border,
    output logic [CNT_W-1:0] fg_count,
    output logic             fg_count_valid
);

    localparam int COL_W  = $clog2(MAX_COLS + 1);
    localparam int ADDR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_COLS);
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_DIL  = 2'd1;
    localparam logic [1:0] MODE_ERO  = 2'd2;

    // Position counters: col_q is the column index the next non-sol pixel will take.
    logic [COL_W-1:0]    col_q, col_d;
    logic [1:0]          row_q, row_d;
    // One bit per column for the previous line (lb1) and the line before that (lb2).
    logic [MAX_COLS-1:0] lb1_q, lb1_d;
    logic [MAX_COLS-1:0] lb2_q, lb2_d;
    // Older window columns: win_a is column c-1, win_b is column c-2; bit2=row r, bit0=row r-2.
    logic [2:0]          win_a_q, win_a_d;
    logic [2:0]          win_b_q, win_b_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_pixel_q, out_pixel_d;
    logic                out_border_q, out_border_d;
    logic [CNT_W-1:0]    fg_count_q, fg_count_d;
    logic                fg_count_valid_q, fg_count_valid_d;

    // Per-pixel combinational terms
    logic                line_start;
    logic [COL_W-1:0]    pix_col;
    logic [1:0]          pix_row;
    logic                in_range;
    logic [ADDR_W-1:0]   addr;
    logic                b, p1, p2;
    logic [2:0]          col_new, old_a, old_b;
    logic [8:0]          win9;
    logic                win_any, win_all, op_res;
    logic                border, res_fg;

    // Locate the pixel, fetch its column from the line buffers and evaluate the operator.
    always_comb begin
        line_start = in_sof | in_sol;
        pix_col    = line_start ? '0 : col_q;
        if (in_sof) begin
            pix_row = 2'd0;
        end else if (in_sol) begin
            pix_row = (row_q == 2'd3) ? 2'd3 : row_q + 2'd1;
        end else begin
            pix_row = row_q;
        end
        in_range = (pix_col < COL_MAX);
        addr     = pix_col[ADDR_W-1:0];
        b        = (in_pixel >= threshold);
        p1       = in_range ? lb1_q[addr] : 1'b0;
        p2       = in_range ? lb2_q[addr] : 1'b0;
        col_new  = {b, p1, p2};
        // Columns from the previous line must not leak into the first pixels of a new one.
        old_a    = line_start ? 3'b000 : win_a_q;
        old_b    = line_start ? 3'b000 : win_b_q;
        win9     = {col_new, old_a, old_b};
        win_any  = |win9;
        win_all  = &win9;
        case (mode_q)
            MODE_BIN: op_res = old_a[1];
            MODE_DIL: op_res = win_any;
            MODE_ERO: op_res = win_all;
            default:  op_res = win_any & ~win_all;
        endcase
        border = (pix_row < 2'd2) | (pix_col < COL_TWO) | ~in_range;
        res_fg = ~border & op_res;
    end

    // Next-state: all state holds unless a pixel is accepted; pulses default low.
    always_comb begin
        col_d            = col_q;
        row_d            = row_q;
        lb1_d            = lb1_q;
        lb2_d            = lb2_q;
        win_a_d          = win_a_q;
        win_b_d          = win_b_q;
        mode_d           = mode_q;
        acc_d            = acc_q;
        out_valid_d      = 1'b0;
        out_pixel_d      = out_pixel_q;
        out_border_d     = out_border_q;
        fg_count_d       = fg_count_q;
        fg_count_valid_d = 1'b0;
        if (in_valid) begin
            if (line_start) begin
                col_d = COL_ONE;
            end else if (col_q != COL_MAX) begin
                col_d = col_q + COL_ONE;
            end
            row_d = pix_row;
            // Read-before-write: p1 was read from lb1 above and ages into lb2.
            if (in_range) begin
                lb1_d[addr] = b;
                lb2_d[addr] = p1;
            end
            win_a_d      = col_new;
            win_b_d      = old_a;
            out_valid_d  = 1'b1;
            out_pixel_d  = {WIDTH{res_fg}};
            out_border_d = border;
            if (in_sof) begin
                mode_d           = mode;
                fg_count_d       = acc_q;
                fg_count_valid_d = 1'b1;
                acc_d            = '0;
            end else if (res_fg && (acc_q != {CNT_W{1'b1}})) begin
                acc_d = acc_q + CNT_W'(1);
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q            <= '0;
            row_q            <= '0;
            lb1_q            <= '0;
            lb2_q            <= '0;
            win_a_q          <= '0;
            win_b_q          <= '0;
            mode_q           <= '0;
            acc_q            <= '0;
            out_valid_q      <= 1'b0;
            out_pixel_q      <= '0;
            out_border_q     <= 1'b0;
            fg_count_q       <= '0;
            fg_count_valid_q <= 1'b0;
        end else begin
            col_q            <= col_d;
            row_q            <= row_d;
            lb1_q            <= lb1_d;
            lb2_q            <= lb2_d;
            win_a_q          <= win_a_d;
            win_b_q          <= win_b_d;
            mode_q           <= mode_d;
            acc_q            <= acc_d;
            out_valid_q      <= out_valid_d;
            out_pixel_q      <= out_pixel_d;
            out_border_q     <= out_border_d;
            fg_count_q       <= fg_count_d;
            fg_count_valid_q <= fg_count_valid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pixel      = out_pixel_q;
    assign out_border     = out_border_q;
    assign fg_count       = fg_count_q;
    assign fg_count_valid = fg_count_valid_q;

endmodule

// File: tb/tb_morph_filter3x3.sv
// Bench for morph_filter3x3: directed frames, expectations queued at issue time, popped by a monitor.
// Latency: expects each output one clock after its accepted input.
// Backpressure: none in the DUT; in_valid gaps are inserted to exercise idle cycles.
module tb_morph_filter3x3;

    localparam int WIDTH = 8;
    localparam int MAXC  = 16;
    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_sof, in_sol;
    logic [WIDTH-1:0] in_pixel, threshold;
    logic [1:0]       mode;
    logic             out_valid, out_border, fg_count_valid;
    logic [WIDTH-1:0] out_pixel;
    logic [CNT_W-1:0] fg_count;

    morph_filter3x3 #(.WIDTH(WIDTH), .MAX_COLS(MAXC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_sol         (in_sol),
        .in_pixel       (in_pixel),
        .threshold      (threshold),
        .mode           (mode),
        .out_valid      (out_valid),
        .out_pixel      (out_pixel),
        .out_border     (out_border),
        .fg_count       (fg_count),
        .fg_count_valid (fg_count_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               x;
        int               y;
        logic             border;
        logic [WIDTH-1:0] pixel;
        logic             cv;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic [WIDTH-1:0] img [0:9][0:19];
    logic vld_dly;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic clear_img(input logic [WIDTH-1:0] v);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 20; x++)
                img[y][x] = v;
    endtask

    task automatic set_block(input int x0, input int y0, input int n, input logic [WIDTH-1:0] v);
        for (int y = y0; y < y0 + n; y++)
            for (int x = x0; x < x0 + n; x++)
                img[y][x] = v;
    endtask

    // Reference: direct 3x3 neighbourhood on the stored frame image, centred at (x-1,y-1).
    function automatic exp_t model(input int x, input int y, input logic [1:0] m);
        exp_t e;
        logic any_b, all_b, ctr, res;
        e.x = x; e.y = y; e.cv = 1'b0; e.cnt = '0;
        e.border = (y < 2) || (x < 2) || (x >= MAXC);
        any_b = 1'b0; all_b = 1'b1; ctr = 1'b0;
        if (!e.border) begin
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++) begin
                    any_b = any_b | (img[y-dy][x-dx] >= threshold);
                    all_b = all_b & (img[y-dy][x-dx] >= threshold);
                end
            ctr = (img[y-1][x-1] >= threshold);
        end
        case (m)
            2'd0:    res = ctr;
            2'd1:    res = any_b;
            2'd2:    res = all_b;
            default: res = any_b & ~all_b;
        endcase
        e.pixel = (!e.border && res) ? {WIDTH{1'b1}} : '0;
        return e;
    endfunction

    // Drives one frame; prev_cnt is the hand-computed count expected at this frame's sof.
    task automatic send_frame(input int w, input int h, input logic [1:0] m_sof,
                              input int sw_row, input logic [1:0] m_sw,
                              input logic [CNT_W-1:0] prev_cnt, input bit gaps, input int rst_at);
        exp_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (gaps) begin
                    int g;
                    g = $urandom_range(0, 2);
                    for (int k = 0; k < g; k++) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                in_valid = 1'b1;
                in_sof   = (x == 0) && (y == 0);
                in_sol   = (x == 0);
                in_pixel = img[y][x];
                mode     = (sw_row >= 0 && y >= sw_row) ? m_sw : m_sof;
                e = model(x, y, m_sof);
                if (x == 0 && y == 0) begin
                    e.cv  = 1'b1;
                    e.cnt = prev_cnt;
                end
                exp_q.push_back(e);
                if (y * w + x == rst_at) begin
                    @(posedge clk);
                    #2;
                    reset_n = 1'b0;
                    #1;
                    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                    chk("rst_out_pixel", {24'd0, out_pixel}, 32'd0);
                    chk("rst_out_border", {31'd0, out_border}, 32'd0);
                    chk("rst_fg_count", {12'd0, fg_count}, 32'd0);
                    chk("rst_fg_count_valid", {31'd0, fg_count_valid}, 32'd0);
                    exp_q.delete();
                    in_valid = 1'b0;
                    in_sof   = 1'b0;
                    in_sol   = 1'b0;
                    #24;
                    reset_n = 1'b1;
                    return;
                end
            end
        end
    endtask

    // Reference for out_valid: in_valid seen at the previous rising edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_dly <= 1'b0;
        else          vld_dly <= in_valid;
    end

    // Monitor: pops one expectation per presented output.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("out_valid_vs_in_valid_dly", {31'd0, out_valid}, {31'd0, vld_dly});
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got out_valid=1, expected no output");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("out_border(%0d,%0d)", e.x, e.y), {31'd0, out_border}, {31'd0, e.border});
                    chk($sformatf("out_pixel(%0d,%0d)", e.x, e.y), {24'd0, out_pixel}, {24'd0, e.pixel});
                    chk($sformatf("fg_count_valid(%0d,%0d)", e.x, e.y), {31'd0, fg_count_valid}, {31'd0, e.cv});
                    if (e.cv)
                        chk("fg_count", {12'd0, fg_count}, {12'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_sol    = 1'b0;
        in_pixel  = '0;
        threshold = 8'h80;
        mode      = 2'd0;
        #23;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_pixel", {24'd0, out_pixel}, 32'd0);
        chk("reset_fg_count", {12'd0, fg_count}, 32'd0);
        chk("reset_fg_count_valid", {31'd0, fg_count_valid}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Dilate of a single pixel: 9 outputs, first sof after reset reports 0.
        clear_img(8'h00); img[5][5] = 8'hFF;
        send_frame(16, 8, 2'd1, -1, 2'd0, 20'd0, 1'b0, -1);
        send_frame(16, 8, 2'd1, -1, 2'd0, 20'd9, 1'b0, -1);
        // Erode of a 3x3 block at exactly threshold over a just-below background.
        clear_img(8'h7F); set_block(4, 4, 3, 8'h80);
        send_frame(16, 8, 2'd2, -1, 2'd0, 20'd9, 1'b0, -1);
        clear_img(8'h00); img[5][5] = 8'hFF;
        send_frame(16, 8, 2'd2, -1, 2'd0, 20'd1, 1'b0, -1);
        // Gradient then binarise of a 5x5 block.
        clear_img(8'h00); set_block(4, 3, 5, 8'hFF);
        send_frame(16, 10, 2'd3, -1, 2'd0, 20'd0, 1'b0, -1);
        send_frame(16, 10, 2'd0, -1, 2'd0, 20'd40, 1'b0, -1);
        // Mode change mid-frame is held off until the next sof.
        clear_img(8'h00); img[5][5] = 8'hFF;
        send_frame(16, 8, 2'd1, 4, 2'd2, 20'd25, 1'b0, -1);
        send_frame(16, 8, 2'd2, -1, 2'd0, 20'd9, 1'b0, -1);
        // Random valid gaps.
        send_frame(16, 8, 2'd1, -1, 2'd0, 20'd0, 1'b1, -1);
        // Over-long lines with foreground beyond MAX_COLS.
        for (int y = 0; y < 10; y++)
            for (int x = 16; x < 20; x++)
                img[y][x] = 8'hFF;
        send_frame(20, 8, 2'd1, -1, 2'd0, 20'd9, 1'b0, -1);
        // Asynchronous reset while a foreground output is presented.
        clear_img(8'h00); img[5][5] = 8'hFF;
        send_frame(16, 8, 2'd1, -1, 2'd0, 20'd9, 1'b0, 6 * 16 + 6);
        repeat (2) @(negedge clk);
        send_frame(16, 8, 2'd1, -1, 2'd0, 20'd0, 1'b0, -1);
        send_frame(1, 1, 2'd1, -1, 2'd0, 20'd9, 1'b0, -1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_sol   = 1'b0;
        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
